decode_stage: RTL

Registered, parametrised instruction-decode stage for the 9-bit miniMips ISA, sitting between instruction fetch and the register file / ALU / data-memory path. It decodes one instruction per cycle into register selects, write enables, an immediate, an ALU operation and memory/bypass controls. Decoded words are held in a two-entry output buffer with valid/ready handshakes on both sides. An optional load-use scoreboard stalls fetch while a source register awaits load data.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered miniMips decode, 2-entry output buffer; DECODE_HAZARD_EN adds a load-use scoreboard
module decode_stage #(
  parameter int IMM_W    = 8,
  parameter int ALU_OP_W = 5,
  parameter int LOAD_LAT = 2,
  parameter int NUM_REGS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          in_instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          r1,
  output logic [1:0]          r2,
  output logic [1:0]          w1,
  output logic [1:0]          w2,
  output logic                we1,
  output logic                we2,
  output logic [IMM_W-1:0]    imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_write,
  output logic                mem_read,
  output logic                alu_bypass,
  output logic                alu_src
);
  localparam int DW = 8 + 2 + IMM_W + ALU_OP_W + 4;
  if (IMM_W < 4 || ALU_OP_W < 5 || LOAD_LAT < 1 || NUM_REGS != 4) begin : g_bad_param
    $error("decode_stage: illegal parameter set");
  end
  logic [2:0]          opc;
  logic [1:0]          d_r1, d_r2, d_w1, d_w2;
  logic                d_we1, d_we2, d_mw, d_mr, d_byp, d_src;
  logic [IMM_W-1:0]    d_imm;
  logic [ALU_OP_W-1:0] d_op;
  logic [3:0]          neg;
  logic [DW-1:0]       d_word, head, skid;
  logic                head_v, skid_v, hazard, push, pop;
  assign opc = in_instr[8:6];
  assign neg = 4'd0 - in_instr[3:0];
  always_comb begin
    d_r1  = '0;
    d_r2  = '0;
    d_w1  = '0;
    d_w2  = '0;
    d_we1 = 1'b0;
    d_we2 = 1'b0;
    d_mw  = 1'b0;
    d_mr  = 1'b0;
    d_byp = 1'b0;
    d_src = 1'b0;
    d_imm = '0;
    d_op  = '0;
    case (opc)
      3'd0: begin
        d_r1  = in_instr[3:2];
        d_r2  = in_instr[5:4];
        d_imm = IMM_W'(in_instr[1:0]);
        d_mw  = 1'b1;
        d_src = 1'b1;
      end
      3'd1: begin
        d_r1  = in_instr[3:2];
        d_w1  = in_instr[5:4];
        d_we1 = 1'b1;
        d_imm = IMM_W'(in_instr[1:0]);
        d_mr  = 1'b1;
        d_src = 1'b1;
      end
      3'd2: begin
        d_w2  = in_instr[5:4];
        d_we2 = 1'b1;
        d_imm = IMM_W'(in_instr[3:0]);
        d_op  = ALU_OP_W'(7);
        d_byp = 1'b1;
        d_src = 1'b1;
      end
      3'd3: begin
        d_r1  = in_instr[5:4];
        d_w2  = in_instr[5:4];
        d_we2 = 1'b1;
        d_byp = 1'b1;
        d_src = 1'b1;
        d_op  = in_instr[3] ? ALU_OP_W'(10) : ALU_OP_W'(11);
        d_imm = IMM_W'(in_instr[3] ? neg : in_instr[3:0]);
      end
      3'd4: begin
        d_byp = 1'b1;
        d_we2 = 1'b1;
        case (in_instr[5:4])
          2'd2: begin
            d_r1 = in_instr[1:0];
            d_r2 = in_instr[1:0];
            d_w2 = in_instr[3:2];
            d_op = ALU_OP_W'(3);
          end
          2'd3: begin
            d_r1  = in_instr[3:2];
            d_w1  = in_instr[3:2];
            d_r2  = in_instr[1:0];
            d_w2  = in_instr[1:0];
            d_we1 = 1'b1;
            d_op  = ALU_OP_W'(2);
          end
          default: begin
            d_r1 = in_instr[3:2];
            d_w2 = in_instr[3:2];
            d_r2 = in_instr[1:0];
            d_op = ALU_OP_W'(in_instr[4]);
          end
        endcase
      end
      3'd5: begin
        d_byp = 1'b1;
        if (in_instr[5:4] == 2'd0) begin
          d_r1 = in_instr[3:2];
          d_r2 = in_instr[1:0];
          d_op = ALU_OP_W'(12);
        end else begin
          d_r2  = in_instr[1:0];
          d_w2  = in_instr[1:0];
          d_we2 = in_instr[5:4] == 2'd3 && in_instr[3:2] != 2'd3;
          case (in_instr[5:2])
            4'b0100: d_op = ALU_OP_W'(13);
            4'b0101: d_op = ALU_OP_W'(14);
            4'b0110: d_op = ALU_OP_W'(15);
            4'b0111: d_op = ALU_OP_W'(16);
            4'b1000: d_op = ALU_OP_W'(17);
            4'b1010: d_op = ALU_OP_W'(18);
            4'b1100: d_op = ALU_OP_W'(4);
            4'b1101: d_op = ALU_OP_W'(5);
            4'b1110: d_op = ALU_OP_W'(6);
            4'b1111: d_op = ALU_OP_W'(20);
            default: d_op = ALU_OP_W'(19);
          endcase
        end
      end
      default: begin
        d_r1  = in_instr[3:2];
        d_r2  = in_instr[1:0];
        d_w2  = in_instr[5:4];
        d_we2 = 1'b1;
        d_byp = 1'b1;
        d_op  = in_instr[6] ? ALU_OP_W'(8) : ALU_OP_W'(9);
      end
    endcase
  end
  assign d_word = {d_r1, d_r2, d_w1, d_w2, d_we1, d_we2, d_imm, d_op, d_mw, d_mr, d_byp, d_src};
`ifdef DECODE_HAZARD_EN
  localparam int CW = $clog2(LOAD_LAT + 1);
  logic [CW-1:0] cnt [NUM_REGS];
  logic          use_r1, use_r2;
  assign use_r1 = opc != 3'd2 && !(opc == 3'd5 && in_instr[5:4] != 2'd0);
  assign use_r2 = opc == 3'd0 || opc[2];
  assign hazard = (use_r1 && cnt[d_r1] != '0) || (use_r2 && cnt[d_r2] != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < NUM_REGS; k++) cnt[k] <= '0;
    else
      for (int k = 0; k < NUM_REGS; k++)
        if (in_valid && in_ready && opc == 3'd1 && d_w1 == 2'(k)) cnt[k] <= CW'(LOAD_LAT);
        else if (cnt[k] != '0) cnt[k] <= cnt[k] - 1'b1;
`else
  assign hazard = 1'b0;
`endif
  assign in_ready  = !skid_v && !hazard;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = head_v && out_ready;
  assign out_valid = head_v;
  assign {r1, r2, w1, w2, we1, we2, imm, alu_op, mem_write, mem_read, alu_bypass, alu_src} = head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= '0;
      skid   <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      head_v <= skid_v || push;
      skid_v <= 1'b0;
      if (skid_v) head <= skid;
      else if (push) head <= d_word;
    end else if (push) begin
      if (head_v) begin
        skid   <= d_word;
        skid_v <= 1'b1;
      end else begin
        head   <= d_word;
        head_v <= 1'b1;
      end
    end
endmodule
